// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and constants for the SDRAM request arbiter.
//   sdram_req_t  - one registered request toward the controller
//   PORT_*       - fixed requester port assignments
//   idx_w()      - width of an index into N things (at least 1 bit)
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 26;

    localparam int PORT_DCACHE = 0;
    localparam int PORT_ICACHE = 1;
    localparam int PORT_BLIT   = 2;

    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] addr;
        logic                    write;
        logic                    burst;
        logic [3:0]              wstrb;
        logic [31:0]             wdata;
    } sdram_req_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: in-order FIFO of requester IDs for issued reads.
//   clock, reset   - rising-edge clock, asynchronous active-low reset
//   push, push_id  - enqueue an owner ID
//   pop            - dequeue the head (ignored when empty)
//   head           - owner of the oldest outstanding read
//   count          - entries held; empty/full flags derived from it
// Push and pop together are accepted at any count, including full.
module arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_id,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop makes room for the push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller request port among NUM_REQ
// requesters (0 dcache, 1 icache, 2 blitter).
//   clock, reset          - rising-edge clock, asynchronous active-low reset
//   req_*                 - per-port request in, ready/rvalid/complete out
//   rsp_rdata/raddress    - read beat data broadcast to all ports
//   sdram_ready/request.. - registered request slot toward the controller
//   sdram_r*/complete     - controller read beats, steered by the ID FIFO
//   arb_error             - sticky: read beat seen with no read outstanding
// Build option: SDRAM_ARB_DCACHE_PRIORITY_EN gives port 0 absolute priority
// and restricts round-robin to ports 1 and above.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ID_DEPTH = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_request,
    input  logic [NUM_REQ-1:0][SDRAM_ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]                    req_write,
    input  logic [NUM_REQ-1:0]                    req_burst,
    input  logic [NUM_REQ-1:0][3:0]               req_wstrb,
    input  logic [NUM_REQ-1:0][31:0]              req_wdata,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_REQ-1:0]                    req_rvalid,
    output logic [NUM_REQ-1:0]                    req_complete,
    output logic [31:0]                           rsp_rdata,
    output logic [SDRAM_ADDR_W-1:0]               rsp_raddress,
    input  logic                                  sdram_ready,
    output logic                                  sdram_request,
    output logic [SDRAM_ADDR_W-1:0]               sdram_addr,
    output logic                                  sdram_write,
    output logic                                  sdram_burst,
    output logic [3:0]                            sdram_wstrb,
    output logic [31:0]                           sdram_wdata,
    input  logic                                  sdram_rvalid,
    input  logic [31:0]                           sdram_rdata,
    input  logic [SDRAM_ADDR_W-1:0]               sdram_raddress,
    input  logic                                  sdram_complete,
    output logic                                  arb_error
);
    localparam int PW = idx_w(NUM_REQ);
    localparam int CW = $clog2(ID_DEPTH) + 1;

    typedef enum logic {S_EMPTY, S_FULL} slot_state_t;

    slot_state_t        state;
    sdram_req_t         slot;
    sdram_req_t         win_req;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      winner;
    logic               grant_any;
    logic               can_grant;
    logic [NUM_REQ-1:0] eligible;

    logic               fifo_push;
    logic               fifo_pop;
    logic [PW-1:0]      fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               beat_ok;

    // Slot can take a new request when empty, or when its current one
    // leaves this cycle.
    assign can_grant = (state == S_EMPTY) || sdram_ready;

    // Reads need a free ID slot; a same-cycle pop does not count, which
    // keeps the grant path independent of the response path.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
        assign eligible[g] = req_request[g] &&
                             (req_write[g] || (fifo_count < CW'(ID_DEPTH)));
    end

    always_comb begin
        int idx;
        grant_any = 1'b0;
        winner    = rr_ptr;
        idx       = 0;
`ifdef SDRAM_ARB_DCACHE_PRIORITY_EN
        if (eligible[PORT_DCACHE]) begin
            grant_any = 1'b1;
            winner    = PW'(PORT_DCACHE);
        end else begin
            // Rotate over ports 1..NUM_REQ-1 starting just after rr_ptr.
            for (int k = 1; k < NUM_REQ; k++) begin
                idx = 1 + ((int'(rr_ptr) - 1 + k + (NUM_REQ - 1)) % (NUM_REQ - 1));
                if (!grant_any && eligible[PW'(idx)]) begin
                    grant_any = 1'b1;
                    winner    = PW'(idx);
                end
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && eligible[PW'(idx)]) begin
                grant_any = 1'b1;
                winner    = PW'(idx);
            end
        end
`endif
        if (!can_grant)
            grant_any = 1'b0;
    end

    always_comb begin
        req_ready = '0;
        if (grant_any)
            req_ready[winner] = 1'b1;
    end

    always_comb begin
        win_req.addr  = req_addr[winner];
        win_req.write = req_write[winner];
        win_req.burst = req_burst[winner];
        win_req.wstrb = req_wstrb[winner];
        win_req.wdata = req_wdata[winner];
    end

    // Output slot FSM; sdram_request mirrors the FULL state as a register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_EMPTY;
            sdram_request <= 1'b0;
            slot          <= '0;
            rr_ptr        <= PW'(NUM_REQ - 1);
        end else begin
            if (grant_any) begin
                state         <= S_FULL;
                sdram_request <= 1'b1;
                slot          <= win_req;
`ifdef SDRAM_ARB_DCACHE_PRIORITY_EN
                if (winner != PW'(PORT_DCACHE))
                    rr_ptr <= winner;
`else
                rr_ptr        <= winner;
`endif
            end else if (state == S_FULL && sdram_ready) begin
                state         <= S_EMPTY;
                sdram_request <= 1'b0;
            end
        end
    end

    assign sdram_addr  = slot.addr;
    assign sdram_write = slot.write;
    assign sdram_burst = slot.burst;
    assign sdram_wstrb = slot.wstrb;
    assign sdram_wdata = slot.wdata;

    // Owner tracking for reads, oldest first.
    assign fifo_push = grant_any && !req_write[winner] && !fifo_full;
    assign fifo_pop  = sdram_complete && !fifo_empty;

    arb_id_fifo #(
        .DEPTH (ID_DEPTH),
        .W     (PW)
    ) u_id_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .push_id (winner),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Response steering is purely combinational.
    assign beat_ok      = sdram_rvalid && !fifo_empty;
    assign rsp_rdata    = sdram_rdata;
    assign rsp_raddress = sdram_raddress;

    always_comb begin
        req_rvalid   = '0;
        req_complete = '0;
        if (beat_ok)
            req_rvalid[fifo_head] = 1'b1;
        if (fifo_pop)
            req_complete[fifo_head] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            arb_error <= 1'b0;
        else if (sdram_rvalid && fifo_empty)
            arb_error <= 1'b1;
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;
    localparam int N = 3;

    logic               clock = 1'b0;
    logic               reset;
    logic [N-1:0]       req_request;
    logic [N-1:0][25:0] req_addr;
    logic [N-1:0]       req_write;
    logic [N-1:0]       req_burst;
    logic [N-1:0][3:0]  req_wstrb;
    logic [N-1:0][31:0] req_wdata;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       req_rvalid;
    logic [N-1:0]       req_complete;
    logic [31:0]        rsp_rdata;
    logic [25:0]        rsp_raddress;
    logic               sdram_ready;
    logic               sdram_request;
    logic [25:0]        sdram_addr;
    logic               sdram_write;
    logic               sdram_burst;
    logic [3:0]         sdram_wstrb;
    logic [31:0]        sdram_wdata;
    logic               sdram_rvalid;
    logic [31:0]        sdram_rdata;
    logic [25:0]        sdram_raddress;
    logic               sdram_complete;
    logic               arb_error;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    sdram_arbiter #(.NUM_REQ(N), .ID_DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_request    (req_request),
        .req_addr       (req_addr),
        .req_write      (req_write),
        .req_burst      (req_burst),
        .req_wstrb      (req_wstrb),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .req_rvalid     (req_rvalid),
        .req_complete   (req_complete),
        .rsp_rdata      (rsp_rdata),
        .rsp_raddress   (rsp_raddress),
        .sdram_ready    (sdram_ready),
        .sdram_request  (sdram_request),
        .sdram_addr     (sdram_addr),
        .sdram_write    (sdram_write),
        .sdram_burst    (sdram_burst),
        .sdram_wstrb    (sdram_wstrb),
        .sdram_wdata    (sdram_wdata),
        .sdram_rvalid   (sdram_rvalid),
        .sdram_rdata    (sdram_rdata),
        .sdram_raddress (sdram_raddress),
        .sdram_complete (sdram_complete),
        .arb_error      (arb_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr();
        req_request    = '0;
        req_addr       = '0;
        req_write      = '0;
        req_burst      = '0;
        req_wstrb      = '0;
        req_wdata      = '0;
        sdram_ready    = 1'b0;
        sdram_rvalid   = 1'b0;
        sdram_rdata    = '0;
        sdram_raddress = '0;
        sdram_complete = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic set_req(input int p, input bit w, input bit b,
                           input logic [25:0] a, input logic [31:0] d);
        req_request[p] = 1'b1;
        req_write[p]   = w;
        req_burst[p]   = b;
        req_addr[p]    = a;
        req_wdata[p]   = d;
        req_wstrb[p]   = 4'hF;
    endtask

    task automatic beat(input logic [31:0] d, input bit last);
        sdram_rvalid   = 1'b1;
        sdram_rdata    = d;
        sdram_raddress = d[25:0];
        sdram_complete = last;
        settle();
    endtask

    task automatic no_beat();
        sdram_rvalid   = 1'b0;
        sdram_complete = 1'b0;
    endtask

    initial begin
        // Reset state
        clr();
        reset = 1'b0;
        #12;
        chk("rst_request",  32'(sdram_request), 32'd0);
        chk("rst_ready",    32'(req_ready),     32'd0);
        chk("rst_rvalid",   32'(req_rvalid),    32'd0);
        chk("rst_complete", 32'(req_complete),  32'd0);
        chk("rst_error",    32'(arb_error),     32'd0);
        chk("rst_addr",     32'(sdram_addr),    32'd0);
        step();
        reset = 1'b1;

        // Single dcache read burst
        set_req(0, 1'b0, 1'b1, 26'h0000100, 32'd0);
        settle();
        chk("b_ready0", 32'(req_ready), 32'd1);
        step();
        req_request[0] = 1'b0;
        settle();
        chk("b_req",   32'(sdram_request), 32'd1);
        chk("b_addr",  32'(sdram_addr),    32'h100);
        chk("b_write", 32'(sdram_write),   32'd0);
        chk("b_burst", 32'(sdram_burst),   32'd1);
        chk("b_noready", 32'(req_ready),   32'd0);
        sdram_ready = 1'b1;
        step();
        sdram_ready = 1'b0;
        settle();
        chk("b_slot_empty", 32'(sdram_request), 32'd0);
        for (int i = 0; i < 16; i++) begin
            beat(32'h0000A000 + 32'(i), i == 15);
            chk("b_rvalid",   32'(req_rvalid),   32'd1);
            chk("b_complete", 32'(req_complete), (i == 15) ? 32'd1 : 32'd0);
            chk("b_rdata",    rsp_rdata,         32'h0000A000 + 32'(i));
            step();
        end
        no_beat();
        settle();
        chk("b_idle_rvalid", 32'(req_rvalid), 32'd0);
        chk("b_error",       32'(arb_error),  32'd0);

        // Three simultaneous writes, sdram_ready high
        do_reset();
        set_req(0, 1'b1, 1'b0, 26'h0000010, 32'h11111111);
        set_req(1, 1'b1, 1'b0, 26'h0000020, 32'h22222222);
        set_req(2, 1'b1, 1'b0, 26'h0000030, 32'h33333333);
        req_wstrb[0] = 4'h3;
        sdram_ready = 1'b1;
        settle();
        chk("w_ready0", 32'(req_ready), 32'd1);
        step();
        req_request[0] = 1'b0;
        settle();
        chk("w_addr0",  32'(sdram_addr),  32'h10);
        chk("w_wdata0", sdram_wdata,      32'h11111111);
        chk("w_wstrb0", 32'(sdram_wstrb), 32'h3);
        chk("w_write0", 32'(sdram_write), 32'd1);
        chk("w_ready1", 32'(req_ready),   32'd2);
        step();
        req_request[1] = 1'b0;
        settle();
        chk("w_addr1",  32'(sdram_addr), 32'h20);
        chk("w_ready2", 32'(req_ready),  32'd4);
        step();
        req_request[2] = 1'b0;
        settle();
        chk("w_addr2",  32'(sdram_addr),    32'h30);
        chk("w_req2",   32'(sdram_request), 32'd1);
        chk("w_none",   32'(req_ready),     32'd0);
        step();
        chk("w_drain",  32'(sdram_request), 32'd0);
        sdram_ready = 1'b0;

        // ID FIFO full: four icache reads, then fifth read plus dcache write
        do_reset();
        sdram_ready = 1'b1;
        set_req(1, 1'b0, 1'b0, 26'h0000200, 32'd0);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("f_ready1", 32'(req_ready), 32'd2);
            step();
        end
        set_req(0, 1'b1, 1'b0, 26'h0000300, 32'h55);
        settle();
        chk("f_write_wins", 32'(req_ready), 32'd1);
        step();
        req_request[0] = 1'b0;
        settle();
        chk("f_waddr",  32'(sdram_addr),  32'h300);
        chk("f_wwrite", 32'(sdram_write), 32'd1);
        chk("f_stall",  32'(req_ready),   32'd0);
        beat(32'h77, 1'b1);
        chk("f_rvalid",     32'(req_rvalid),   32'd2);
        chk("f_complete",   32'(req_complete), 32'd2);
        chk("f_stall_pop",  32'(req_ready),    32'd0);
        step();
        no_beat();
        settle();
        chk("f_freed", 32'(req_ready), 32'd2);
        step();
        req_request[1] = 1'b0;
        settle();
        chk("f_raddr",  32'(sdram_addr),  32'h200);
        chk("f_rwrite", 32'(sdram_write), 32'd0);

        // Interleaved owners: icache burst, then dcache single read
        do_reset();
        sdram_ready = 1'b1;
        set_req(1, 1'b0, 1'b1, 26'h0000400, 32'd0);
        settle();
        chk("i_ready1", 32'(req_ready), 32'd2);
        step();
        req_request[1] = 1'b0;
        set_req(0, 1'b0, 1'b0, 26'h0000500, 32'd0);
        settle();
        chk("i_ready0", 32'(req_ready),  32'd1);
        chk("i_addr1",  32'(sdram_addr), 32'h400);
        step();
        req_request[0] = 1'b0;
        settle();
        chk("i_addr0", 32'(sdram_addr), 32'h500);
        for (int i = 0; i < 16; i++) begin
            beat(32'(i), i == 15);
            chk("i_rvalid1",   32'(req_rvalid),   32'd2);
            chk("i_complete1", 32'(req_complete), (i == 15) ? 32'd2 : 32'd0);
            step();
        end
        beat(32'h0000BEEF, 1'b1);
        chk("i_rvalid0",   32'(req_rvalid),   32'd1);
        chk("i_complete0", 32'(req_complete), 32'd1);
        chk("i_rdata",     rsp_rdata,         32'h0000BEEF);
        chk("i_raddr",     32'(rsp_raddress), 32'h0000BEEF);
        step();
        no_beat();
        settle();
        chk("i_error", 32'(arb_error), 32'd0);

        // Controller stalled for five cycles
        do_reset();
        set_req(2, 1'b1, 1'b0, 26'h0000600, 32'h0000CAFE);
        settle();
        chk("s_ready2", 32'(req_ready), 32'd4);
        step();
        req_request[2] = 1'b0;
        set_req(0, 1'b1, 1'b0, 26'h0000700, 32'd1);
        set_req(1, 1'b1, 1'b0, 26'h0000800, 32'd2);
        settle();
        for (int k = 0; k < 5; k++) begin
            chk("s_req",   32'(sdram_request), 32'd1);
            chk("s_addr",  32'(sdram_addr),    32'h600);
            chk("s_wdata", sdram_wdata,        32'h0000CAFE);
            chk("s_hold",  32'(req_ready),     32'd0);
            step();
        end
        sdram_ready = 1'b1;
        settle();
        chk("s_release", 32'(req_ready), 32'd1);
        step();
        req_request[0] = 1'b0;
        settle();
        chk("s_next_addr",  32'(sdram_addr), 32'h700);
        chk("s_next_ready", 32'(req_ready),  32'd2);
        step();
        req_request[1] = 1'b0;
        sdram_ready = 1'b0;

        // Stray beat with an empty FIFO
        do_reset();
        settle();
        chk("e_clear", 32'(arb_error), 32'd0);
        beat(32'h1234, 1'b0);
        chk("e_dropped", 32'(req_rvalid), 32'd0);
        step();
        no_beat();
        settle();
        chk("e_set", 32'(arb_error), 32'd1);
        step();
        step();
        chk("e_sticky", 32'(arb_error), 32'd1);
        do_reset();
        settle();
        chk("e_reset", 32'(arb_error), 32'd0);

        // Reset in the middle of a burst discards outstanding owners
        sdram_ready = 1'b1;
        set_req(0, 1'b0, 1'b1, 26'h0000900, 32'd0);
        settle();
        step();
        req_request[0] = 1'b0;
        beat(32'h1, 1'b0);
        chk("m_first_beat", 32'(req_rvalid), 32'd1);
        step();
        do_reset();
        beat(32'h2, 1'b0);
        chk("m_dropped", 32'(req_rvalid), 32'd0);
        step();
        no_beat();
        settle();
        chk("m_error", 32'(arb_error), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
